// File: rtl/interrupt_unit.sv
// Vectored interrupt unit: synchronised edge-triggered requests, mask, global
// enable and a three-state handshake with the controller (IDLE/REQ/SERV).
module interrupt_unit #(
  parameter int            NIRQ    = 8,
  parameter int            AW      = 8,
  parameter logic [AW-1:0] VECBASE = 8'hE0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] maskIn,
  input  logic            MASKld,
  input  logic            MASKclr,
  input  logic            intEnable,
  input  logic            intDisable,
  input  logic            clrPend,
  output logic            intPending,
  output logic [AW-1:0]   HVPIaddr,
  output logic [NIRQ-1:0] pendReg,
  output logic [NIRQ-1:0] maskReg
);

  localparam int IW = $clog2(NIRQ);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

  state_t          state, state_next;
  logic [NIRQ-1:0] sync1, sync2, sync3;
  logic [NIRQ-1:0] rise, active, pend_clr;
  logic [IW-1:0]   idx, hit_idx;
  logic            ie, capture, ack;

  assign rise     = sync2 & ~sync3;
  assign active   = pendReg & maskReg;
  assign pend_clr = ack ? (NIRQ'(1) << idx) : '0;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) hit_idx = IW'(i);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (ie && (|active)) begin
          state_next = REQ;
          capture    = 1'b1;
        end
      end
      REQ: begin
        if (clrPend) begin
          ack        = 1'b1;
          state_next = SERV;
        end else if (!maskReg[idx]) begin
          state_next = IDLE;
        end
      end
      SERV: begin
        if (ie) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      pendReg    <= '0;
      maskReg    <= '0;
      ie         <= 1'b0;
      idx        <= '0;
      intPending <= 1'b0;
      HVPIaddr   <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      sync3 <= sync2;

      // A new edge on the same cycle as the acknowledge must not be lost.
      pendReg <= (pendReg & ~pend_clr) | rise;

      if (MASKclr)     maskReg <= '0;
      else if (MASKld) maskReg <= maskIn;

      if (intDisable || ack) ie <= 1'b0;
      else if (intEnable)    ie <= 1'b1;

      if (capture) idx <= hit_idx;

      // Presentation lags the state register by one edge.
      intPending <= (state == REQ);
      if (state == REQ) HVPIaddr <= VECBASE + AW'(idx);
    end
  end

endmodule
